// File: rtl/opalkelly_tx_arbiter.sv
// opalkelly_tx_arbiter: round-robin, packet-atomic arbiter feeding the Opal Kelly pipe-out sys_tx port.
// Ports: sys_clk/sys_rst (async active-high); src_valid/src_last/src_data/src_ready per-source stream
// inputs (source i on src_data[16*i+15:16*i]); sys_tx_ready/sys_tx_valid/sys_tx pipe handshake;
// grant one-hot owner (0 when idle); busy high outside IDLE.
// Optional header word per grant: define OPALKELLY_TX_ARB_HEADER_EN.
module opalkelly_tx_arbiter #(
    parameter int NUM_CH    = 4,
    parameter int MAX_BURST = 256
) (
    input  logic                  sys_clk,
    input  logic                  sys_rst,
    input  logic [NUM_CH-1:0]     src_valid,
    input  logic [NUM_CH-1:0]     src_last,
    input  logic [16*NUM_CH-1:0]  src_data,
    output logic [NUM_CH-1:0]     src_ready,
    input  logic                  sys_tx_ready,
    output logic                  sys_tx_valid,
    output logic [15:0]           sys_tx,
    output logic [NUM_CH-1:0]     grant,
    output logic                  busy
);
    localparam int IW = $clog2(NUM_CH);
    localparam int CW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {
        IDLE,
`ifdef OPALKELLY_TX_ARB_HEADER_EN
        HDR,
`endif
        STREAM
    } state_t;

    state_t          state, state_n;
    logic [IW-1:0]   ptr, win;
    logic [CW-1:0]   cnt;
    logic            stream, hdr, xfer, done;
    logic [15:0]     hdr_word;

`ifdef OPALKELLY_TX_ARB_HEADER_EN
    logic [7:0] seq;
    localparam state_t FIRST = HDR;
    assign hdr      = state == HDR;
    assign hdr_word = {5'b10100, 3'(ptr), seq};
`else
    localparam state_t FIRST = STREAM;
    assign hdr      = 1'b0;
    assign hdr_word = '0;
`endif

    // ptr doubles as the index of the granted source once a grant is made.
    assign stream       = state == STREAM;
    assign busy         = state != IDLE;
    assign sys_tx_valid = (stream & src_valid[ptr]) | hdr;
    assign sys_tx       = stream ? src_data[16*int'(ptr) +: 16] : hdr ? hdr_word : '0;
    assign src_ready    = stream ? grant & {NUM_CH{sys_tx_ready}} : '0;
    assign xfer         = sys_tx_valid & sys_tx_ready;
    assign done         = stream & xfer & (src_last[ptr] | (cnt == CW'(MAX_BURST - 1)));

    // Scan downward so the nearest requester after ptr is the last one assigned.
    always_comb begin
        win = ptr;
        for (int k = NUM_CH; k >= 1; k--)
            if (src_valid[(int'(ptr) + k) % NUM_CH]) win = IW'((int'(ptr) + k) % NUM_CH);
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = |src_valid ? FIRST : IDLE;
`ifdef OPALKELLY_TX_ARB_HEADER_EN
            HDR:     state_n = sys_tx_ready ? STREAM : HDR;
`endif
            STREAM:  state_n = done ? IDLE : STREAM;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) state <= IDLE;
        else         state <= state_n;

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            grant <= '0;
            ptr   <= IW'(NUM_CH - 1);
            cnt   <= '0;
        end else begin
            if (state == IDLE && |src_valid) begin
                grant <= {{(NUM_CH-1){1'b0}}, 1'b1} << win;
                ptr   <= win;
            end
            if (!stream) cnt <= '0;
            else if (xfer) cnt <= cnt + 1'b1;
            if (done) grant <= '0;
        end
    end

`ifdef OPALKELLY_TX_ARB_HEADER_EN
    always_ff @(posedge sys_clk or posedge sys_rst)
        if (sys_rst) seq <= '0;
        else if (hdr && sys_tx_ready) seq <= seq + 8'd1;
`endif
endmodule

// File: tb/tb_opalkelly_tx_arbiter.sv
// tb_opalkelly_tx_arbiter: directed vectors plus randomized packet traffic against a queue-based model.
module tb_opalkelly_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;

    logic            sys_clk = 1'b0;
    logic            sys_rst = 1'b1;
    logic [N-1:0]    src_valid = '0, src_last = '0, src_ready, grant;
    logic [16*N-1:0] src_data = '0;
    logic            sys_tx_ready = 1'b0, sys_tx_valid, busy;
    logic [15:0]     sys_tx;

    opalkelly_tx_arbiter #(.NUM_CH(N), .MAX_BURST(MB)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .src_valid(src_valid), .src_last(src_last),
        .src_data(src_data), .src_ready(src_ready), .sys_tx_ready(sys_tx_ready),
        .sys_tx_valid(sys_tx_valid), .sys_tx(sys_tx), .grant(grant), .busy(busy)
    );

    always #5 sys_clk = ~sys_clk;

    int n_checks = 0, n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    typedef struct {
        logic v; logic l; logic [15:0] d; logic r;
        logic ev; logic [15:0] etx; logic [3:0] eg; logic [3:0] erdy; logic eb;
    } vec_t;
    typedef struct { logic [15:0] d; logic l; } word_t;
    typedef struct { int s; logic [15:0] d; } exp_t;

    vec_t    tbl[11];
    word_t   sq[N][$];
    int      rd[N];
    exp_t    eq[$];

    task automatic drive_src();
        for (int i = 0; i < N; i++) begin
            if (rd[i] < sq[i].size()) begin
                src_valid[i]        = 1'b1;
                src_last[i]         = sq[i][rd[i]].l;
                src_data[16*i +: 16] = sq[i][rd[i]].d;
            end else begin
                src_valid[i]        = 1'b0;
                src_last[i]         = 1'b0;
                src_data[16*i +: 16] = '0;
            end
        end
    endtask

    // Reference: round-robin over sources with pending words, each grant taking
    // words until a last flag or MB words, optionally preceded by a header word.
    task automatic build_model();
        int ptr = N - 1, seq = 0, c = 0, n;
        int idx[N];
        bit more = 1'b1, last;
        for (int i = 0; i < N; i++) idx[i] = 0;
        while (more) begin
            more = 1'b0;
            for (int k = 1; k <= N; k++) begin
                c = (ptr + k) % N;
                if (idx[c] < sq[c].size()) begin more = 1'b1; break; end
            end
            if (!more) break;
            ptr = c;
`ifdef OPALKELLY_TX_ARB_HEADER_EN
            eq.push_back('{c, 16'hA000 | 16'(c << 8) | 16'(seq)});
            seq = (seq + 1) % 256;
`endif
            n = 0;
            do begin
                eq.push_back('{c, sq[c][idx[c]].d});
                last = sq[c][idx[c]].l;
                idx[c]++;
                n++;
            end while (!last && n < MB);
        end
    endtask

    initial begin
        int cyc, left, len, s;
        logic [N-1:0] pg, sx;
        exp_t e;
        //           v  l  d        r   ev etx       eg    erdy  eb
        tbl[0]  = '{1, 0, 16'h1111, 1, 0, 16'h0000, 4'h0, 4'h0, 0};
        tbl[1]  = '{1, 0, 16'h1111, 1, 1, 16'h1111, 4'h1, 4'h1, 1};
        tbl[2]  = '{1, 0, 16'h2222, 0, 1, 16'h2222, 4'h1, 4'h0, 1};
        tbl[3]  = '{1, 0, 16'h2222, 0, 1, 16'h2222, 4'h1, 4'h0, 1};
        tbl[4]  = '{1, 0, 16'h2222, 1, 1, 16'h2222, 4'h1, 4'h1, 1};
        tbl[5]  = '{1, 0, 16'h3333, 1, 1, 16'h3333, 4'h1, 4'h1, 1};
        tbl[6]  = '{1, 1, 16'h4444, 1, 1, 16'h4444, 4'h1, 4'h1, 1};
        tbl[7]  = '{0, 0, 16'h0000, 1, 0, 16'h0000, 4'h0, 4'h0, 0};
        tbl[8]  = '{1, 1, 16'h7777, 1, 0, 16'h0000, 4'h0, 4'h0, 0};
        tbl[9]  = '{1, 1, 16'h7777, 1, 1, 16'h7777, 4'h1, 4'h1, 1};
        tbl[10] = '{0, 0, 16'h0000, 1, 0, 16'h0000, 4'h0, 4'h0, 0};

        @(negedge sys_clk);
        check("reset_grant", grant, 0);
        check("reset_busy", busy, 0);
        check("reset_valid", sys_tx_valid, 0);
        check("reset_ready", src_ready, 0);
        check("reset_tx", sys_tx, 0);
        @(posedge sys_clk); #1 sys_rst = 1'b0;

`ifndef OPALKELLY_TX_ARB_HEADER_EN
        foreach (tbl[i]) begin
            src_valid = {3'b0, tbl[i].v};
            src_last  = {3'b0, tbl[i].l};
            src_data  = {48'h0, tbl[i].d};
            sys_tx_ready = tbl[i].r;
            @(negedge sys_clk);
            check($sformatf("vec%0d_valid", i), sys_tx_valid, tbl[i].ev);
            check($sformatf("vec%0d_tx", i), sys_tx, tbl[i].etx);
            check($sformatf("vec%0d_grant", i), grant, tbl[i].eg);
            check($sformatf("vec%0d_ready", i), src_ready, tbl[i].erdy);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].eb);
            @(posedge sys_clk); #1;
        end
`endif

        // Reset in the middle of a 5-word packet, then source 0 must win first.
        src_valid = 4'b0001; src_last = '0; src_data = 64'h5001; sys_tx_ready = 1'b1;
`ifdef OPALKELLY_TX_ARB_HEADER_EN
        @(posedge sys_clk); #1;
`endif
        @(posedge sys_clk); #1;
        @(posedge sys_clk); #1 src_data = 64'h5002;
        @(posedge sys_clk); #1 src_data = 64'h5003;
        #2 sys_rst = 1'b1;
        #1;
        check("midrst_grant", grant, 0);
        check("midrst_busy", busy, 0);
        check("midrst_valid", sys_tx_valid, 0);
        check("midrst_ready", src_ready, 0);
        check("midrst_tx", sys_tx, 0);
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        src_valid = 4'b0101;
        @(negedge sys_clk);
        check("postrst_idle", grant, 0);
        @(negedge sys_clk);
        check("postrst_first", grant, 4'b0001);
        sys_rst = 1'b1; src_valid = '0; src_data = '0;
        @(posedge sys_clk); #1 sys_rst = 1'b0;

        // Randomized packet traffic with random pipe backpressure.
        for (int p = 0; p < 320; p++) begin
            s   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 7);
            for (int w = 0; w < len; w++) sq[s].push_back('{16'($urandom), w == len - 1});
        end
        for (int i = 0; i < N; i++) rd[i] = 0;
        build_model();
        cyc = 0;
        pg  = '0;
        while (eq.size() > 0 && cyc < 20000) begin
            drive_src();
            sys_tx_ready = $urandom_range(0, 3) != 0;
            @(negedge sys_clk);
            if (grant != 0 && grant != pg) check("bubble", pg, 0);
            pg = grant;
            if (sys_tx_valid && sys_tx_ready) begin
                e = eq.pop_front();
                check("word", sys_tx, e.d);
                check("owner", grant, 32'(1) << e.s);
            end
            sx = src_valid & src_ready;
            @(posedge sys_clk); #1;
            for (int i = 0; i < N; i++) if (sx[i]) rd[i]++;
            cyc++;
        end
        check("expected_drained", eq.size(), 0);
        left = 0;
        for (int i = 0; i < N; i++) left += sq[i].size() - rd[i];
        check("sources_drained", left, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/opalkelly_tx_arbiter.md
# opalkelly_tx_arbiter

Round-robin arbiter that shares the single 16-bit system-side transmit port of the Opal Kelly pipe-out FIFO among `NUM_CH` stream sources. It grants one source at a time and holds the grant for a whole packet, or until a burst limit, so that words from different sources never interleave in the host stream. It sits in the `sys_clk` domain, directly in front of the pipe's `sys_tx_ready`/`sys_tx_valid`/`sys_tx` handshake.

## Interface
Parameters:
- `NUM_CH`, default 4: number of sources; legal range 2..8.
- `MAX_BURST`, default 256: maximum words per grant; legal range 1..4096.

Ports:
- `sys_clk` in 1: system clock; all logic is on the rising edge.
- `sys_rst` in 1: reset; **asynchronous, active-high**.
- `src_valid` in `NUM_CH`: per-source word valid.
- `src_last` in `NUM_CH`: per-source end-of-packet, qualified by `src_valid`.
- `src_data` in `16*NUM_CH`: source *i* drives bits `[16*i+15:16*i]`.
- `src_ready` out `NUM_CH`: per-source accept.
- `sys_tx_ready` in 1: from the pipe; high means the FIFO can take a word.
- `sys_tx_valid` out 1: word valid to the pipe.
- `sys_tx` out 16: word to the pipe.
- `grant` out `NUM_CH`: one-hot current owner; zero when idle.
- `busy` out 1: high in any state other than IDLE.

## Operation
- A transfer occurs on any cycle where valid and ready are both high.
- FSM states are IDLE, HDR and STREAM. HDR exists only with the header feature (see Configuration).
- **IDLE**
  - `sys_tx_valid`=0, `src_ready`=0.
  - If any `src_valid` is high, select the first requester searching from `ptr+1` upward, modulo `NUM_CH`.
  - Register the winner into `grant` and update `ptr` to the winner.
  - Go to HDR if the header feature is compiled in, else STREAM.
- **STREAM** (granted source *g*)
  - `sys_tx_valid = src_valid[g]`, `sys_tx = src_data[g]`, `src_ready[g] = sys_tx_ready`.
  - All other `src_ready` bits are 0.
  - These paths are combinational; no data register.
- **Burst counter**
  - Width `clog2(MAX_BURST)+1`.
  - Cleared on entry to STREAM; incremented on each STREAM transfer.
- **End of grant:** a transfer with `src_last[g]`=1, or the transfer that brings the counter to `MAX_BURST`.
  - On the next edge: `grant`=0, go to IDLE.
  - A packet cut by `MAX_BURST` resumes at a later grant. No word is dropped or duplicated.
- **Deasserted `src_valid[g]` mid-packet:** the grant is held and the arbiter waits. There is no timeout.
- **Simultaneous requests:** resolved only by the round-robin pointer. Requests arriving while busy wait until IDLE.

## Timing
- **Reset values:**
  - Outputs: `grant`=0, `busy`=0, `sys_tx_valid`=0, `src_ready`=0, `sys_tx`=0.
  - State: state=IDLE, `ptr`=`NUM_CH-1` (source 0 wins first), burst count=0, `seq`=0.
- **Reset mid-packet:** everything returns to the reset values immediately (asynchronous assert). The partial packet is abandoned. Release is synchronised externally by the existing reset scheme.
- **Arbitration latency:** request seen in IDLE → `grant` valid on the next edge.
  - First data word can transfer 1 cycle after the request (no header) or 2 cycles after (header).
- **Bubble:** exactly one idle cycle between consecutive grants.
- **Back-to-back rate:** one word per cycle within a grant while `src_valid[g]` and `sys_tx_ready` stay high.
- **Backpressure:** `sys_tx_ready` low stalls without loss. `sys_tx` and `sys_tx_valid` simply follow the granted source.

## Configuration
- **Macro:** `OPALKELLY_TX_ARB_HEADER_EN`.
- **Defined:**
  - Each grant starts in HDR, which drives `sys_tx_valid`=1 and `sys_tx = {5'b10100, ch[2:0], seq[7:0]}`, with every `src_ready`=0.
  - HDR stays until `sys_tx_ready`, then goes to STREAM.
  - `seq` is an 8-bit counter that increments after each header transfer and wraps 255→0.
  - Headers are emitted for burst-cut continuations too.
- **Undefined:** no HDR state, no `seq` register; IDLE goes straight to STREAM.

## Test plan
- **Single packet:** source 0 sends `0x1111`, `0x2222`, `0x3333` (last on third), `sys_tx_ready`=1 → pipe receives exactly those 3 words on consecutive cycles; `grant` returns to 0 the cycle after.
- **Round-robin fairness:** all 4 sources each present 2-word packets continuously → grant order 0,1,2,3,0; one bubble between grants; no interleaving of sources.
- **Backpressure:** `sys_tx_ready` toggles 1,0,0,1 during a 4-word packet → no word lost or duplicated; `src_ready[g]` mirrors `sys_tx_ready`.
- **Burst limit:** `MAX_BURST`=4, source 1 sends 6 words with last on the 6th while source 2 is waiting → 4 words from 1, then source 2's packet, then words 5-6 from 1.
- **Reset mid-packet:** assert `sys_rst` after the 2nd of 5 words → all outputs 0 within the same cycle; after release, source 0 wins first.
- **Header enabled:** source 3 sends 1 word, twice → stream is `0xA300`, data, `0xA301`, data; `seq` wraps from `0xFF` to `0x00` after 256 packets.
